// File: rtl/regfile_write_arbiter_if.sv
// regfile_write_arbiter_if: requester handshake and register-file write port bundle
interface regfile_write_arbiter_if #(
  parameter int NREQ = 3,
  parameter int AW   = 5,
  parameter int DW   = 32
);
  logic                 Stall;
  logic [NREQ-1:0]      ReqValid;
  logic [NREQ*AW-1:0]   ReqAddr;
  logic [NREQ*DW-1:0]   ReqData;
  logic [NREQ-1:0]      ReqReady;
  logic                 RegWrite;
  logic [AW-1:0]        WriteRegister;
  logic [DW-1:0]        WriteData;
  logic [1:0]           GrantId;
  logic [15:0]          ZeroDropCount;
  modport master (
    output Stall, ReqValid, ReqAddr, ReqData,
    input  ReqReady, RegWrite, WriteRegister, WriteData, GrantId, ZeroDropCount
  );
  modport slave (
    input  Stall, ReqValid, ReqAddr, ReqData,
    output ReqReady, RegWrite, WriteRegister, WriteData, GrantId, ZeroDropCount
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: round-robin arbiter sharing the register-file write port,
// registering one write per cycle and dropping (and counting) writes to register 0.
module regfile_write_arbiter #(
  parameter int NREQ = 3,
  parameter int AW   = 5,
  parameter int DW   = 32
) (
  input logic Clk,
  input logic Reset,
  regfile_write_arbiter_if.slave bus
);
  logic [3:0]          valid4;
  logic [3:0][AW-1:0]  addr4;
  logic [3:0][DW-1:0]  data4;
  logic [3:0]          ready4;
  logic [1:0]          ptr_q, ptr_d;
  logic                reg_write_q, reg_write_d;
  logic [AW-1:0]       write_register_q, write_register_d;
  logic [DW-1:0]       write_data_q, write_data_d;
  logic [1:0]          grant_id_q, grant_id_d;
  logic [15:0]         zero_drop_q, zero_drop_d;
  logic [2:0]          sum;
  logic [1:0]          idx;
  logic [1:0]          gnt_id;
  logic                found;
  logic                xfer;
  logic                addr_zero;
  // Pad requester vectors to four slots so a 2-bit index is always in range.
  for (genvar i = 0; i < 4; i++) begin : g_pad
    if (i < NREQ) begin : g_real
      assign valid4[i] = bus.ReqValid[i];
      assign addr4[i]  = bus.ReqAddr[i*AW +: AW];
      assign data4[i]  = bus.ReqData[i*DW +: DW];
    end else begin : g_none
      assign valid4[i] = 1'b0;
      assign addr4[i]  = '0;
      assign data4[i]  = '0;
    end
  end
  // Scan from lowest to highest priority so the last hit is the winner.
  always_comb begin
    found  = 1'b0;
    gnt_id = 2'd0;
    sum    = 3'd0;
    idx    = 2'd0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      sum = {1'b0, ptr_q} + 3'(k);
      idx = (sum >= 3'(NREQ)) ? 2'(sum - 3'(NREQ)) : sum[1:0];
      if (valid4[idx]) begin
        found  = 1'b1;
        gnt_id = idx;
      end
    end
  end
  assign xfer         = found && !bus.Stall && !Reset;
  assign ready4       = xfer ? (4'b0001 << gnt_id) : 4'b0000;
  assign bus.ReqReady = ready4[NREQ-1:0];
  assign addr_zero    = (addr4[gnt_id] == '0);
  always_comb begin
    reg_write_d      = xfer && !addr_zero;
    write_register_d = xfer ? addr4[gnt_id] : write_register_q;
    write_data_d     = xfer ? data4[gnt_id] : write_data_q;
    grant_id_d       = xfer ? gnt_id : grant_id_q;
    ptr_d            = !xfer ? ptr_q : (gnt_id == 2'(NREQ - 1)) ? 2'd0 : gnt_id + 2'd1;
    zero_drop_d      = (xfer && addr_zero && zero_drop_q != 16'hFFFF) ? zero_drop_q + 16'd1 : zero_drop_q;
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      ptr_q            <= 2'd0;
      reg_write_q      <= 1'b0;
      write_register_q <= '0;
      write_data_q     <= '0;
      grant_id_q       <= 2'd0;
      zero_drop_q      <= 16'd0;
    end else begin
      ptr_q            <= ptr_d;
      reg_write_q      <= reg_write_d;
      write_register_q <= write_register_d;
      write_data_q     <= write_data_d;
      grant_id_q       <= grant_id_d;
      zero_drop_q      <= zero_drop_d;
    end
  end
  assign bus.RegWrite      = reg_write_q;
  assign bus.WriteRegister = write_register_q;
  assign bus.WriteData     = write_data_q;
  assign bus.GrantId       = grant_id_q;
  assign bus.ZeroDropCount = zero_drop_q;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: directed scenarios with hand-computed expectations
module tb_regfile_write_arbiter;
  localparam int NREQ = 3, AW = 5, DW = 32;
  logic Clk = 1'b0;
  logic Reset;
  int vec = 0;
  int err = 0;
  regfile_write_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();
  regfile_write_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (.Clk(Clk), .Reset(Reset), .bus(bus));
  always #5 Clk = ~Clk;

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.ReqAddr[i*AW +: AW] = a;
    bus.ReqData[i*DW +: DW] = d;
  endtask

  task automatic test_reset();
    @(negedge Clk);
    Reset = 1'b1;
    @(posedge Clk); #1;
    vec++; if (bus.ReqReady !== 3'b000) begin err++; $display("FAIL rst_ready got %b want 000", bus.ReqReady); end
    vec++; if ({bus.RegWrite, bus.WriteRegister, bus.WriteData, bus.GrantId, bus.ZeroDropCount} !== '0) begin
      err++; $display("FAIL rst_outputs got we=%b wr=%0d wd=%h gid=%0d zdc=%0d want all 0", bus.RegWrite, bus.WriteRegister, bus.WriteData, bus.GrantId, bus.ZeroDropCount); end
    @(negedge Clk);
    Reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge Clk);
      vec++; if (bus.ReqReady !== 3'b000 || bus.RegWrite !== 1'b0 || bus.WriteRegister !== '0 || bus.WriteData !== '0) begin
        err++; $display("FAIL idle_%0d got ready=%b we=%b wr=%0d wd=%h want 000/0/0/0", c, bus.ReqReady, bus.RegWrite, bus.WriteRegister, bus.WriteData); end
    end
  endtask

  task automatic test_single();
    @(negedge Clk);
    set_req(0, 5'd5, 32'hDEADBEEF);
    bus.ReqValid = 3'b001;
    #1;
    vec++; if (bus.ReqReady !== 3'b001) begin err++; $display("FAIL single_ready got %b want 001", bus.ReqReady); end
    @(posedge Clk); #1;
    vec++; if (bus.RegWrite !== 1'b1 || bus.WriteRegister !== 5'd5 || bus.WriteData !== 32'hDEADBEEF || bus.GrantId !== 2'd0) begin
      err++; $display("FAIL single_write got we=%b wr=%0d wd=%h gid=%0d want 1/5/deadbeef/0", bus.RegWrite, bus.WriteRegister, bus.WriteData, bus.GrantId); end
    @(negedge Clk);
    bus.ReqValid = 3'b000;
    @(posedge Clk); #1;
    vec++; if (bus.RegWrite !== 1'b0 || bus.WriteRegister !== 5'd5 || bus.WriteData !== 32'hDEADBEEF) begin
      err++; $display("FAIL single_after got we=%b wr=%0d wd=%h want 0/5/deadbeef", bus.RegWrite, bus.WriteRegister, bus.WriteData); end
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_ready;
    do_reset();
    for (int i = 0; i < 3; i++) set_req(i, 5'(i + 1), 32'hA000_0000 + 32'(i));
    bus.ReqValid = 3'b111;
    for (int k = 0; k < 6; k++) begin
      exp_ready = 3'b001 << (k % 3);
      #1;
      vec++; if (bus.ReqReady !== exp_ready) begin err++; $display("FAIL rr_ready_%0d got %b want %b", k, bus.ReqReady, exp_ready); end
      @(posedge Clk); #1;
      vec++; if (bus.RegWrite !== 1'b1 || bus.GrantId !== 2'(k % 3) || bus.WriteRegister !== 5'(k % 3 + 1) || bus.WriteData !== 32'hA000_0000 + 32'(k % 3)) begin
        err++; $display("FAIL rr_write_%0d got we=%b gid=%0d wr=%0d wd=%h want 1/%0d/%0d/%h", k, bus.RegWrite, bus.GrantId, bus.WriteRegister, bus.WriteData, k % 3, k % 3 + 1, 32'hA000_0000 + 32'(k % 3)); end
      @(negedge Clk);
    end
    bus.ReqValid = 3'b000;
  endtask

  task automatic test_zero_drop();
    @(negedge Clk);
    set_req(1, 5'd0, 32'h1234);
    bus.ReqValid = 3'b010;
    #1;
    vec++; if (bus.ReqReady !== 3'b010) begin err++; $display("FAIL zero_ready got %b want 010", bus.ReqReady); end
    @(posedge Clk); #1;
    vec++; if (bus.RegWrite !== 1'b0 || bus.ZeroDropCount !== 16'd1 || bus.GrantId !== 2'd1 || bus.WriteData !== 32'h1234) begin
      err++; $display("FAIL zero_first got we=%b zdc=%0d gid=%0d wd=%h want 0/1/1/1234", bus.RegWrite, bus.ZeroDropCount, bus.GrantId, bus.WriteData); end
    repeat (65534) @(posedge Clk);
    #1;
    vec++; if (bus.ZeroDropCount !== 16'hFFFF) begin err++; $display("FAIL zero_full got %h want ffff", bus.ZeroDropCount); end
    repeat (3) @(posedge Clk);
    #1;
    vec++; if (bus.ZeroDropCount !== 16'hFFFF || bus.RegWrite !== 1'b0) begin
      err++; $display("FAIL zero_sat got zdc=%h we=%b want ffff/0", bus.ZeroDropCount, bus.RegWrite); end
    @(negedge Clk);
    bus.ReqValid = 3'b000;
  endtask

  task automatic test_stall();
    @(negedge Clk);
    set_req(0, 5'd9, 32'h0000_0009);
    bus.ReqValid = 3'b001;
    @(posedge Clk); #1;
    vec++; if (bus.GrantId !== 2'd0 || bus.RegWrite !== 1'b1) begin err++; $display("FAIL stall_pre got gid=%0d we=%b want 0/1", bus.GrantId, bus.RegWrite); end
    @(negedge Clk);
    set_req(1, 5'd11, 32'hB1);
    set_req(2, 5'd12, 32'hB2);
    bus.ReqValid = 3'b110;
    bus.Stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      vec++; if (bus.ReqReady !== 3'b000) begin err++; $display("FAIL stall_ready_%0d got %b want 000", c, bus.ReqReady); end
      @(posedge Clk); #1;
      vec++; if (bus.RegWrite !== 1'b0) begin err++; $display("FAIL stall_we_%0d got %b want 0", c, bus.RegWrite); end
      @(negedge Clk);
    end
    bus.Stall = 1'b0;
    #1;
    vec++; if (bus.ReqReady !== 3'b010) begin err++; $display("FAIL stall_first got %b want 010", bus.ReqReady); end
    @(posedge Clk); #1;
    vec++; if (bus.GrantId !== 2'd1 || bus.WriteRegister !== 5'd11 || bus.RegWrite !== 1'b1) begin
      err++; $display("FAIL stall_g1 got gid=%0d wr=%0d we=%b want 1/11/1", bus.GrantId, bus.WriteRegister, bus.RegWrite); end
    @(negedge Clk);
    #1;
    vec++; if (bus.ReqReady !== 3'b100) begin err++; $display("FAIL stall_second got %b want 100", bus.ReqReady); end
    @(posedge Clk); #1;
    vec++; if (bus.GrantId !== 2'd2 || bus.WriteRegister !== 5'd12 || bus.WriteData !== 32'hB2) begin
      err++; $display("FAIL stall_g2 got gid=%0d wr=%0d wd=%h want 2/12/b2", bus.GrantId, bus.WriteRegister, bus.WriteData); end
    @(negedge Clk);
    bus.ReqValid = 3'b000;
  endtask

  task automatic test_reset_mid();
    @(negedge Clk);
    set_req(0, 5'd3, 32'hC0);
    bus.ReqValid = 3'b001;
    @(posedge Clk); #1;
    vec++; if (bus.GrantId !== 2'd0 || bus.RegWrite !== 1'b1) begin err++; $display("FAIL rmid_pre got gid=%0d we=%b want 0/1", bus.GrantId, bus.RegWrite); end
    @(negedge Clk);
    set_req(2, 5'd7, 32'hC2);
    bus.ReqValid = 3'b101;
    Reset = 1'b1;
    #1;
    vec++; if (bus.ReqReady !== 3'b000) begin err++; $display("FAIL rmid_ready got %b want 000", bus.ReqReady); end
    @(posedge Clk); #1;
    vec++; if (bus.RegWrite !== 1'b0 || bus.GrantId !== 2'd0 || bus.WriteRegister !== '0 || bus.ZeroDropCount !== 16'd0) begin
      err++; $display("FAIL rmid_out got we=%b gid=%0d wr=%0d zdc=%0d want 0/0/0/0", bus.RegWrite, bus.GrantId, bus.WriteRegister, bus.ZeroDropCount); end
    @(negedge Clk);
    Reset = 1'b0;
    #1;
    vec++; if (bus.ReqReady !== 3'b001) begin err++; $display("FAIL rmid_ptr got %b want 001", bus.ReqReady); end
    @(posedge Clk); #1;
    vec++; if (bus.GrantId !== 2'd0 || bus.WriteRegister !== 5'd3) begin err++; $display("FAIL rmid_g0 got gid=%0d wr=%0d want 0/3", bus.GrantId, bus.WriteRegister); end
    @(negedge Clk);
    bus.ReqValid = 3'b100;
    #1;
    vec++; if (bus.ReqReady !== 3'b100) begin err++; $display("FAIL rmid_ready2 got %b want 100", bus.ReqReady); end
    @(posedge Clk); #1;
    vec++; if (bus.GrantId !== 2'd2 || bus.WriteRegister !== 5'd7 || bus.WriteData !== 32'hC2 || bus.RegWrite !== 1'b1) begin
      err++; $display("FAIL rmid_g2 got gid=%0d wr=%0d wd=%h we=%b want 2/7/c2/1", bus.GrantId, bus.WriteRegister, bus.WriteData, bus.RegWrite); end
    @(negedge Clk);
    bus.ReqValid = 3'b000;
  endtask

  initial begin
    Reset = 1'b1;
    bus.Stall = 1'b0;
    bus.ReqValid = '0;
    bus.ReqAddr = '0;
    bus.ReqData = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_zero_drop();
    test_stall();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
